// File: rtl/cvxif_pkg.sv
// cvxif_pkg: shared definitions for the CVXIF issue controller.
//   - CUSTOM3 opcode and posit funct3 codes
//   - issue_state_t FSM encoding
//   - instruction field helpers (rs1, rs2, rd)
package cvxif_pkg;

   localparam logic [6:0] CUSTOM3_OPCODE = 7'b1111011;

   localparam logic [2:0] F3_ADD = 3'd0;
   localparam logic [2:0] F3_SUB = 3'd1;
   localparam logic [2:0] F3_MUL = 3'd2;
   localparam logic [2:0] F3_DIV = 3'd3;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      REGS     = 2'd2,
      WAIT_RES = 2'd3
   } issue_state_t;

   function automatic logic [4:0] instr_rs1(input logic [31:0] i);
      return i[19:15];
   endfunction

   function automatic logic [4:0] instr_rs2(input logic [31:0] i);
      return i[24:20];
   endfunction

   function automatic logic [4:0] instr_rd(input logic [31:0] i);
      return i[11:7];
   endfunction

endpackage

// File: rtl/cvxif_regfile.sv
// cvxif_regfile: 32x32 integer register file.
//   ra0/ra1 -> rd0/rd1   combinational operand reads
//   dbg_addr -> dbg_rdata combinational debug read
//   wb_*                  result writeback port (wins over debug)
//   dbg_we/dbg_wdata      debug write port, usable any time
// x0 is never written, so it always reads zero.
module cvxif_regfile (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  ra0,
   input  logic [4:0]  ra1,
   output logic [31:0] rd0,
   output logic [31:0] rd1,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        dbg_we,
   input  logic [4:0]  dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic [31:0] dbg_rdata
);

   logic [31:0] rf [32];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else begin
         // Writeback is issued second so it overrides a same-address debug write.
         if (dbg_we && dbg_addr != 5'd0) rf[dbg_addr] <= dbg_wdata;
         if (wb_we  && wb_addr  != 5'd0) rf[wb_addr]  <= wb_data;
      end
   end

   assign rd0       = (ra0      == 5'd0) ? '0 : rf[ra0];
   assign rd1       = (ra1      == 5'd0) ? '0 : rf[ra1];
   assign dbg_rdata = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];

endmodule

// File: rtl/cvxif_issue_ctrl.sv
// cvxif_issue_ctrl: core-side CVXIF issue controller for the posit unit.
//   instr_*      driver handshake; one instruction in flight at a time
//   dbg_*        debug register-file access
//   issue_*      offer instruction to the coprocessor, take its response
//   register_*   operands, presented for exactly one cycle after accept
//   result_*     coprocessor result, written back to rd when requested
//   retire_*     registered retirement report (valid is a 1-cycle pulse)
//   reject       1-cycle pulse when the coprocessor refuses the offer
//   timeout      1-cycle pulse when no result arrives in TIMEOUT_CYCLES
module cvxif_issue_ctrl
   import cvxif_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   input  logic        dbg_we,
   input  logic [4:0]  dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic [31:0] dbg_rdata,
   output logic        issue_valid,
   input  logic        issue_ready,
   output logic [31:0] issue_req_instr,
   input  logic        issue_resp_accept,
   input  logic        issue_resp_writeback,
   input  logic [1:0]  issue_resp_register_read,
   output logic        register_valid,
   output logic [31:0] register_rs0,
   output logic [31:0] register_rs1,
   output logic [1:0]  register_rs_valid,
   input  logic        result_valid,
   output logic        result_ready,
   input  logic [31:0] result_data,
   output logic        retire_valid,
   output logic [4:0]  retire_rd,
   output logic [31:0] retire_data,
   output logic        reject,
   output logic        timeout
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   issue_state_t  state_q, state_d;
   logic [31:0]   instr_q;
   logic          wb_q;
   logic [1:0]    rsv_q;
   logic [CW-1:0] cnt_q;

   logic capture, accept, cnt_clr, cnt_inc, retire_en, rf_we;
   logic [4:0] rd_addr;

   assign rd_addr = instr_rd(instr_q);

   always_comb begin
      state_d        = state_q;
      instr_ready    = 1'b0;
      issue_valid    = 1'b0;
      register_valid = 1'b0;
      result_ready   = 1'b0;
      reject         = 1'b0;
      timeout        = 1'b0;
      capture        = 1'b0;
      accept         = 1'b0;
      cnt_clr        = 1'b0;
      cnt_inc        = 1'b0;
      retire_en      = 1'b0;
      rf_we          = 1'b0;
      case (state_q)
         IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               capture = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            issue_valid = 1'b1;
            if (issue_ready) begin
               if (issue_resp_accept) begin
                  accept  = 1'b1;
                  state_d = REGS;
               end else begin
                  reject  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         REGS: begin
            register_valid = 1'b1;
            cnt_clr        = 1'b1;
            state_d        = WAIT_RES;
         end
         WAIT_RES: begin
            result_ready = 1'b1;
            // A result arriving on the last allowed cycle still wins over timeout.
            if (result_valid) begin
               retire_en = 1'b1;
               rf_we     = wb_q && (rd_addr != 5'd0);
               state_d   = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               timeout = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         instr_q      <= '0;
         wb_q         <= 1'b0;
         rsv_q        <= '0;
         cnt_q        <= '0;
         retire_valid <= 1'b0;
         retire_rd    <= '0;
         retire_data  <= '0;
      end else begin
         state_q      <= state_d;
         retire_valid <= retire_en;
         if (capture) instr_q <= instr;
         if (accept) begin
            wb_q  <= issue_resp_writeback;
            rsv_q <= issue_resp_register_read;
         end
         if (cnt_clr)                         cnt_q <= '0;
         else if (cnt_inc && cnt_q != '1)     cnt_q <= cnt_q + 1'b1;
         if (retire_en) begin
            retire_rd   <= rd_addr;
            retire_data <= result_data;
         end
      end
   end

   assign issue_req_instr   = instr_q;
   assign register_rs_valid = rsv_q;

   cvxif_regfile u_rf (
      .clk       (clk),
      .rst_n     (rst_n),
      .ra0       (instr_rs1(instr_q)),
      .ra1       (instr_rs2(instr_q)),
      .rd0       (register_rs0),
      .rd1       (register_rs1),
      .wb_we     (rf_we),
      .wb_addr   (rd_addr),
      .wb_data   (result_data),
      .dbg_we    (dbg_we),
      .dbg_addr  (dbg_addr),
      .dbg_wdata (dbg_wdata),
      .dbg_rdata (dbg_rdata)
   );

endmodule
